// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe: 4-stage streaming Barrett reducer, out_data = in_data mod Q.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_data/in_tag upstream;
//   out_valid/out_ready/out_data/out_tag downstream. MODRED_RANGE_CHK_EN adds
//   out_err, set when the operand is >= Q*Q.
module barrett_reduce_pipe #(
   parameter int unsigned Q          = 8380417,
   parameter int          Q_WIDTH    = 23,
   parameter int          DATA_WIDTH = 46,
   parameter int          TAG_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [Q_WIDTH-1:0]    out_data,
   output logic [TAG_WIDTH-1:0]  out_tag
`ifdef MODRED_RANGE_CHK_EN
   ,
   output logic                  out_err
`endif
);

   localparam int K = Q_WIDTH;
   localparam int W = 2*K + 2;
   localparam logic [W-1:0] QW   = W'(Q);
   localparam logic [W-1:0] MU_W = (W'(1) << (2*K)) / QW;
   localparam logic [K:0]   MU   = MU_W[K:0];
   localparam logic [K+1:0] Q1R  = QW[K+1:0];
   localparam logic [K+1:0] Q2R  = {QW[K:0], 1'b0};

   if (DATA_WIDTH > 2*Q_WIDTH) begin : g_bad_width
      $error("barrett_reduce_pipe: DATA_WIDTH exceeds 2*Q_WIDTH");
   end
   if ((QW <= (W'(1) << (K-1))) || (QW >= (W'(1) << K))) begin : g_bad_q
      $error("barrett_reduce_pipe: Q outside (2^(Q_WIDTH-1), 2^Q_WIDTH)");
   end

   logic           stall;
   logic           adv;
   logic [2*K-1:0] x_ext;

   logic           v1, v2, v3;
   logic [K+1:0]   s1_x, s2_x, s3_r;
   logic [K:0]     s1_q1;
   logic [W-1:0]   s2_q2;
   logic [TAG_WIDTH-1:0] s1_tag, s2_tag, s3_tag;

   logic [K:0]     q3;
   logic [K+1:0]   r_d;
   logic [K+1:0]   r_fix;
   logic           unused_bits;

   assign stall    = out_valid & ~out_ready;
   assign adv      = ~stall;
   assign in_ready = ~stall;

   assign x_ext = (2*K)'(in_data);

   // Only the high half of q2 feeds the quotient estimate.
   assign q3 = s2_q2[W-1:K+1];

   // The true remainder is below 3Q < 2^(K+2), so low bits suffice.
   assign r_d = s2_x - (K+2)'(q3) * Q1R;

   always_comb begin
      r_fix = s3_r;
      if (s3_r >= Q2R) begin
         r_fix = s3_r - Q2R;
      end else if (s3_r >= Q1R) begin
         r_fix = s3_r - Q1R;
      end
   end

   assign unused_bits = ^{s2_q2[K:0], r_fix[K+1:K]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         out_valid <= 1'b0;
         s1_x      <= '0;
         s1_q1     <= '0;
         s1_tag    <= '0;
         s2_x      <= '0;
         s2_q2     <= '0;
         s2_tag    <= '0;
         s3_r      <= '0;
         s3_tag    <= '0;
         out_data  <= '0;
         out_tag   <= '0;
      end else if (adv) begin
         v1        <= in_valid;
         v2        <= v1;
         v3        <= v2;
         out_valid <= v3;
         if (in_valid) begin
            s1_x   <= x_ext[K+1:0];
            s1_q1  <= x_ext[2*K-1:K-1];
            s1_tag <= in_tag;
         end
         if (v1) begin
            s2_x   <= s1_x;
            s2_q2  <= W'(s1_q1) * W'(MU);
            s2_tag <= s1_tag;
         end
         if (v2) begin
            s3_r   <= r_d;
            s3_tag <= s2_tag;
         end
         if (v3) begin
            out_data <= r_fix[K-1:0];
            out_tag  <= s3_tag;
         end
      end
   end

`ifdef MODRED_RANGE_CHK_EN
   localparam logic [W-1:0]   QQ_W = QW * QW;
   localparam logic [2*K-1:0] QQ   = QQ_W[2*K-1:0];

   logic e1, e2, e3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e1      <= 1'b0;
         e2      <= 1'b0;
         e3      <= 1'b0;
         out_err <= 1'b0;
      end else if (adv) begin
         if (in_valid) e1      <= (x_ext >= QQ);
         if (v1)       e2      <= e1;
         if (v2)       e3      <= e2;
         if (v3)       out_err <= e3;
      end
   end
`endif

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// tb_barrett_reduce_pipe: vector table, stall, reset and random streaming
// checks of barrett_reduce_pipe against a plain x % Q reference.
module tb_barrett_reduce_pipe;

   localparam longint unsigned QL = 64'd8380417;
   localparam longint unsigned QQ = QL * QL;
   localparam int NV = 11;

   typedef struct {
      logic [45:0]     x;
      longint unsigned data;
      bit              err;
   } vec_t;

   typedef struct {
      longint unsigned data;
      logic [7:0]      tag;
      bit              err;
   } exp_t;

   typedef struct {
      longint unsigned data;
      logic [7:0]      tag;
      bit              err;
      int              cyc;
   } got_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [45:0] in_data;
   logic [7:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [22:0] out_data;
   logic [7:0]  out_tag;
`ifdef MODRED_RANGE_CHK_EN
   logic        out_err;
`endif

   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   hs_cyc = 0;
   bit   rand_rdy = 0;
   exp_t exp_q[$];
   got_t got_q[$];
   vec_t tbl[NV];

   barrett_reduce_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
`ifdef MODRED_RANGE_CHK_EN
      ,
      .out_err   (out_err)
`endif
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   function automatic exp_t model(input logic [45:0] x, input logic [7:0] t);
      exp_t e;
      longint unsigned xv;
      xv     = 64'(x);
      e.data = xv % QL;
      e.tag  = t;
      e.err  = (xv >= QQ);
      return e;
   endfunction

   function automatic bit dut_err();
`ifdef MODRED_RANGE_CHK_EN
      return out_err;
`else
      return 1'b0;
`endif
   endfunction

   // Scoreboard: every accepted operand must leave in order, and a
   // stalled output must already show the head-of-queue result.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) exp_q.push_back(model(in_data, in_tag));
         if (out_valid) begin
            if (out_ready) got_q.push_back('{64'(out_data), out_tag, dut_err(), cyc});
            if (exp_q.size() == 0) begin
               check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
               check(out_ready ? "sb_data" : "hold_data", 64'(out_data), exp_q[0].data);
               check(out_ready ? "sb_tag" : "hold_tag", 64'(out_tag), 64'(exp_q[0].tag));
`ifdef MODRED_RANGE_CHK_EN
               check(out_ready ? "sb_err" : "hold_err", 64'(out_err), 64'(exp_q[0].err));
`endif
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic send(input logic [45:0] x, input logic [7:0] t);
      int n;
      bit hs;
      n = 0;
      hs = 0;
      in_valid = 1;
      in_data  = x;
      in_tag   = t;
      do begin
         @(negedge clk);
         hs = in_ready;
         if (hs) hs_cyc = cyc;
         n++;
         @(posedge clk);
         #1;
      end while (!hs && n < 200);
      if (!hs) check("send_timeout", 64'd0, 64'd1);
      in_valid = 0;
   endtask

   task automatic wait_got(input int n, input string name);
      int k;
      k = 0;
      while (got_q.size() < n && k < 500) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1;
      check(name, 64'(got_q.size()), 64'(n));
   endtask

   initial begin
      int base;
      int c0;
      logic [63:0] r64;
      logic [45:0] x;

      tbl[0]  = '{46'd0,              64'd0,       1'b0};
      tbl[1]  = '{46'd8380416,        64'd8380416, 1'b0};
      tbl[2]  = '{46'd8380417,        64'd0,       1'b0};
      tbl[3]  = '{46'd16760834,       64'd0,       1'b0};
      tbl[4]  = '{46'd70231372333056, 64'd1,       1'b0};
      tbl[5]  = '{46'd70368744177663, 64'd49144,   1'b1};
      tbl[6]  = '{46'd70231389093889, 64'd0,       1'b1};
      tbl[7]  = '{46'd70231389093888, 64'd8380416, 1'b0};
      tbl[8]  = '{46'd8388608,        64'd8191,    1'b0};
      tbl[9]  = '{46'd35184372088832, 64'd4214781, 1'b0};
      tbl[10] = '{46'd16760833,       64'd8380416, 1'b0};

      rst_n     = 0;
      in_valid  = 0;
      in_data   = '0;
      in_tag    = '0;
      out_ready = 1;

      #23;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data",  64'(out_data),  64'd0);
      check("rst_out_tag",   64'(out_tag),   64'd0);
`ifdef MODRED_RANGE_CHK_EN
      check("rst_out_err",   64'(out_err),   64'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Vector table, back-to-back, downstream always ready.
      base = got_q.size();
      c0 = 0;
      for (int i = 0; i < NV; i++) begin
         send(tbl[i].x, 8'(i + 1));
         if (i == 0) c0 = hs_cyc;
      end
      wait_got(base + NV, "tbl_count");
      for (int i = 0; i < NV && base + i < got_q.size(); i++) begin
         check($sformatf("tbl_data[%0d]", i), got_q[base+i].data, tbl[i].data);
         check($sformatf("tbl_tag[%0d]", i), 64'(got_q[base+i].tag), 64'(i + 1));
         check($sformatf("tbl_lat[%0d]", i), 64'(got_q[base+i].cyc), 64'(c0 + i + 4));
`ifdef MODRED_RANGE_CHK_EN
         check($sformatf("tbl_err[%0d]", i), 64'(got_q[base+i].err), 64'(tbl[i].err));
`endif
      end

      // Random stream with random backpressure and occasional bubbles.
      base = got_q.size();
      rand_rdy = 1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            r64 = {$urandom(), $urandom()};
            in_valid = 0;
            in_data  = r64[45:0];
            in_tag   = 8'($urandom());
            @(posedge clk);
            #1;
         end
         r64 = {$urandom(), $urandom()};
         case ($urandom_range(0, 7))
            0:       x = 46'($urandom_range(0, 8380416));
            1:       x = 46'(QL * 64'($urandom_range(0, 8388607)));
            default: x = r64[45:0];
         endcase
         send(x, 8'($urandom()));
      end
      rand_rdy = 0;
      @(posedge clk);
      #2;
      out_ready = 1;
      wait_got(base + 1000, "rnd_count");
      check("rnd_drain", 64'(exp_q.size()), 64'd0);

      // Fill the pipe against a blocked output, then release.
      out_ready = 0;
      base = got_q.size();
      send(46'd8380422, 8'hA1);
      send(46'd25141258, 8'hA2);
      send(46'd70368744177662, 8'hA3);
      send(46'd12345, 8'hA4);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("stall_in_ready[%0d]", i), 64'(in_ready), 64'd0);
         check($sformatf("stall_out_valid[%0d]", i), 64'(out_valid), 64'd1);
      end
      @(posedge clk);
      #1;
      check("stall_held", 64'(exp_q.size()), 64'd4);
      check("stall_no_out", 64'(got_q.size()), 64'(base));
      out_ready = 1;
      wait_got(base + 4, "stall_release");
      for (int j = 1; j < 4 && base + j < got_q.size(); j++) begin
         check($sformatf("stall_consec[%0d]", j), 64'(got_q[base+j].cyc),
               64'(got_q[base].cyc + j));
      end
      check("stall_drain", 64'(exp_q.size()), 64'd0);

      // Reset with three operands in flight.
      base = got_q.size();
      send(46'd100, 8'hB1);
      send(46'd200, 8'hB2);
      send(46'd300, 8'hB3);
      rst_n = 0;
      exp_q.delete();
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_data",  64'(out_data),  64'd0);
      check("mid_rst_tag",   64'(out_tag),   64'd0);
      @(posedge clk);
      #1;
      rst_n = 1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check($sformatf("post_rst_valid[%0d]", i), 64'(out_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      check("post_rst_none", 64'(got_q.size()), 64'(base));
      send(46'd25141262, 8'hC1);
      wait_got(base + 1, "post_rst_recover");
      if (got_q.size() > base) begin
         check("post_rst_data", got_q[base].data, 64'd11);
         check("post_rst_tag", 64'(got_q[base].tag), 64'hC1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
